// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_arb_pkg                                                       |
// | Brief    : Shared types and default widths for the write-port arbiter.     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package wb_arb_pkg;

    localparam int c_DEF_DEPTH     = 2;
    localparam int c_DEF_DATA_W    = 32;
    localparam int c_DEF_ADDR_W    = 5;
    localparam int c_DEF_MAX_DEFER = 4;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_MDU  = 2'd3
    } arb_src_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_arb_fifo                                                      |
// | Brief    : DEPTH-entry circular buffer of {dest,data} for MDU results.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH  = c_DEF_DEPTH,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_dest,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]  r_mem_dest [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= f_next(r_wr_ptr);
            if (pop)
                r_rd_ptr <= f_next(r_rd_ptr);
            if (push && !pop)
                r_count <= r_count + CNT_W'(1);
            else if (pop && !push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem_dest[r_wr_ptr] <= push_dest;
            r_mem_data[r_wr_ptr] <= push_data;
        end
    end

    assign head_dest = r_mem_dest[r_rd_ptr];
    assign head_data = r_mem_data[r_rd_ptr];
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_write_arbiter                                                 |
// | Brief    : Shares the register-file write port between WB and the MDU.     |
// |            Define WB_ARB_PERF_EN to add conflict/drain perf counters.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int ADDR_W    = c_DEF_ADDR_W,
    parameter int MAX_DEFER = c_DEF_MAX_DEFER,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_dest,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_data,
    output logic              pipe_stall,
    output logic [CNT_W-1:0]  buf_count
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       drain_cnt
`endif
);

    localparam int c_DEF_W = $clog2(MAX_DEFER + 1);

    arb_state_t         r_state;
    logic [c_DEF_W-1:0] r_defer_cnt;
    arb_src_t           w_sel;
    logic               w_mdu_xfer;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_head_dest;
    logic [DATA_W-1:0]  w_head_data;
    logic [CNT_W-1:0]   w_count;

    assign mdu_ready  = rst && (w_count < CNT_W'(DEPTH)) && (r_state == NORMAL);
    assign w_mdu_xfer = mdu_valid && mdu_ready;

    always_comb begin
        w_sel = SRC_NONE;
        if (r_state == DRAIN)
            w_sel = (w_count != '0) ? SRC_BUF : SRC_NONE;
        else if (pipe_we && (pipe_dest != '0))
            w_sel = SRC_PIPE;
        else if (w_count != '0)
            w_sel = SRC_BUF;
        else if (w_mdu_xfer && (mdu_dest != '0))
            w_sel = SRC_MDU;
    end

    // A handshake to r0 completes but is discarded rather than buffered.
    assign w_pop  = (w_sel == SRC_BUF);
    assign w_push = w_mdu_xfer && (mdu_dest != '0) && (w_sel != SRC_MDU);

    wb_arb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_dest (mdu_dest),
        .push_data (mdu_data),
        .pop       (w_pop),
        .head_dest (w_head_dest),
        .head_data (w_head_data),
        .count     (w_count)
    );

    assign buf_count = w_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we       <= 1'b0;
            rf_dest     <= '0;
            rf_data     <= '0;
            pipe_stall  <= 1'b0;
            r_state     <= NORMAL;
            r_defer_cnt <= '0;
        end else begin
            rf_we <= (w_sel != SRC_NONE);
            case (w_sel)
                SRC_PIPE: begin
                    rf_dest <= pipe_dest;
                    rf_data <= pipe_data;
                end
                SRC_BUF: begin
                    rf_dest <= w_head_dest;
                    rf_data <= w_head_data;
                end
                SRC_MDU: begin
                    rf_dest <= mdu_dest;
                    rf_data <= mdu_data;
                end
                default: ;
            endcase

            case (r_state)
                NORMAL: begin
                    if (w_pop || (w_count == '0)) begin
                        r_defer_cnt <= '0;
                    end else if (w_sel == SRC_PIPE) begin
                        r_defer_cnt <= r_defer_cnt + c_DEF_W'(1);
                        // The loss that reaches the limit forces a drain next cycle.
                        if (r_defer_cnt == c_DEF_W'(MAX_DEFER - 1)) begin
                            r_state    <= DRAIN;
                            pipe_stall <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_count <= CNT_W'(1)) begin
                        r_state     <= NORMAL;
                        pipe_stall  <= 1'b0;
                        r_defer_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= NORMAL;
                    pipe_stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
            drain_cnt    <= '0;
        end else begin
            if ((w_sel == SRC_PIPE) && ((w_count != '0) || mdu_valid) && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 32'd1;
            if ((r_state == DRAIN) && (drain_cnt != '1))
                drain_cnt <= drain_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_write_arbiter                                              |
// | Brief    : Directed self-checking bench for wb_write_arbiter (defaults).   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_dest = '0;
    logic [31:0] pipe_data = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_dest = '0;
    logic [31:0] mdu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_data;
    logic        pipe_stall;
    logic [1:0]  buf_count;
`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt;
    logic [31:0] drain_cnt;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    wb_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_dest  (pipe_dest),
        .pipe_data  (pipe_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_dest   (mdu_dest),
        .mdu_data   (mdu_data),
        .rf_we      (rf_we),
        .rf_dest    (rf_dest),
        .rf_data    (rf_data),
        .pipe_stall (pipe_stall),
        .buf_count  (buf_count)
`ifdef WB_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .drain_cnt    (drain_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pd, input logic mv,
                         input logic [4:0] md, input logic [31:0] mdata);
        pipe_we   = pw;
        pipe_dest = pd;
        pipe_data = 32'h100 + 32'(pd);
        mdu_valid = mv;
        mdu_dest  = md;
        mdu_data  = mdata;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] d,
                          input logic [31:0] data, input logic [1:0] cnt);
        chk({tag, "_we"},   32'(rf_we), 32'(we));
        chk({tag, "_dest"}, 32'(rf_dest), 32'(d));
        chk({tag, "_data"}, rf_data, data);
        chk({tag, "_cnt"},  32'(buf_count), 32'(cnt));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_rf("rst", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_ready", 32'(mdu_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(mdu_ready), 32'd1);

        // Single pipeline write, then hold when idle
        drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        pipe_data = 32'hA5;
        tick();
        chk_rf("pipe_wr", 1'b1, 5'd3, 32'hA5, 2'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("pipe_idle", 1'b0, 5'd3, 32'hA5, 2'd0);

        // Simultaneous pipe r4 and MDU r7: pipe first, buffered MDU next
        drive(1'b1, 5'd4, 1'b1, 5'd7, 32'h11);
        tick();
        chk_rf("coll_pipe", 1'b1, 5'd4, 32'h104, 2'd1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("coll_buf", 1'b1, 5'd7, 32'h11, 2'd0);
        tick();
        chk("coll_idle_we", 32'(rf_we), 32'd0);

        // Register 0 writes dropped; MDU handshake still completes
        drive(1'b1, 5'd0, 1'b1, 5'd0, 32'h99);
        #1;
        chk("r0_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("r0_drop", 1'b0, 5'd7, 32'h11, 2'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

        // Fill buffer under continuous pipe writes, force a drain
        drive(1'b1, 5'd10, 1'b1, 5'd20, 32'hD0);
        tick();
        chk_rf("fill_a", 1'b1, 5'd10, 32'h10A, 2'd1);
        drive(1'b1, 5'd11, 1'b1, 5'd21, 32'hD1);
        tick();
        chk_rf("fill_b", 1'b1, 5'd11, 32'h10B, 2'd2);
        chk("full_ready", 32'(mdu_ready), 32'd0);
        drive(1'b1, 5'd12, 1'b1, 5'd22, 32'hD2);
        tick();
        chk_rf("fill_c", 1'b1, 5'd12, 32'h10C, 2'd2);
        chk("fill_c_stall", 32'(pipe_stall), 32'd0);
        drive(1'b1, 5'd13, 1'b1, 5'd22, 32'hD2);
        tick();
        chk_rf("fill_d", 1'b1, 5'd13, 32'h10D, 2'd2);
        chk("fill_d_stall", 32'(pipe_stall), 32'd0);
        drive(1'b1, 5'd14, 1'b1, 5'd22, 32'hD2);
        tick();
        chk_rf("fill_e", 1'b1, 5'd14, 32'h10E, 2'd2);
        chk("drain_enter", 32'(pipe_stall), 32'd1);
        chk("drain_ready", 32'(mdu_ready), 32'd0);
        drive(1'b1, 5'd15, 1'b1, 5'd22, 32'hD2);
        tick();
        chk_rf("drain_1", 1'b1, 5'd20, 32'hD0, 2'd1);
        chk("drain_1_stall", 32'(pipe_stall), 32'd1);
        tick();
        chk_rf("drain_2", 1'b1, 5'd21, 32'hD1, 2'd0);
        chk("drain_exit", 32'(pipe_stall), 32'd0);
        chk("drain_exit_ready", 32'(mdu_ready), 32'd1);
        tick();
        chk_rf("post_drain", 1'b1, 5'd15, 32'h10F, 2'd1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_rf("post_pop", 1'b1, 5'd22, 32'hD2, 2'd0);

        // Reset asserted mid-drain
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(1 + i), 1'b1, 5'(8 + i), 32'hE0 + 32'(i));
            tick();
        end
        chk("pre_rst_stall", 32'(pipe_stall), 32'd1);
        chk("pre_rst_cnt", 32'(buf_count), 32'd2);
        rst = 1'b0;
        tick();
        chk_rf("mid_rst", 1'b0, 5'd0, 32'h0, 2'd0);
        chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
        chk("mid_rst_ready", 32'(mdu_ready), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        chk_rf("after_rst", 1'b0, 5'd0, 32'h0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
